// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: answers a host start pulse with the
// 30/80/80 us preamble and a 40-bit payload frame on an open-drain line.
module dht11_responder #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int START_MIN_US = 18000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       data_in,
  output logic       data_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       done
);

  localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [15:0]   T_START = 16'(START_MIN_US);
  localparam logic [15:0]   T_DLY   = 16'd30;
  localparam logic [15:0]   T_RESP  = 16'd80;
  localparam logic [15:0]   T_BLOW  = 16'd50;
  localparam logic [15:0]   T_ZERO  = 16'd26;
  localparam logic [15:0]   T_ONE   = 16'd70;
  localparam logic [15:0]   T_END   = 16'd50;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    WAIT_REL,
    RESP_DELAY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [PW-1:0] pre_q;
  logic [15:0]   us_q;
  logic [5:0]    bit_q;
  logic [39:0]   shr_q;
  logic          oe_q;
  logic          busy_q;
  logic          done_q;

  logic          line;
  logic          us_tick;
  logic [7:0]    csum_d;
  logic [15:0]   hi_us_d;

  assign line    = sync_q[1];
  assign data_oe = oe_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Checksum, current bit's high time and the microsecond strobe.
  always_comb begin
    csum_d  = hum_int + hum_dec + temp_int + temp_dec;
    hi_us_d = shr_q[39] ? T_ONE : T_ZERO;
    us_tick = (pre_q == PRE_MAX);
  end

  // Two-flop synchronizer; resets to the idle (pulled-up) level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], data_in};
  end

  // Free-running prescaler producing one us_tick per microsecond.
  always_ff @(posedge clk) begin
    if (rst)          pre_q <= '0;
    else if (us_tick) pre_q <= '0;
    else              pre_q <= pre_q + PW'(1);
  end

  // Protocol FSM with phase timer, frame shifter and registered outputs.
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      us_q    <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      us_q    <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (us_tick && us_q != 16'hFFFF) us_q <= us_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          oe_q <= 1'b0;
          if (!line) begin
            state_q <= START_LOW;
            us_q    <= '0;
          end
        end
        START_LOW: begin
          if (line) begin
            state_q <= IDLE;
            us_q    <= '0;
          end else if (us_q >= T_START) begin
            state_q <= WAIT_REL;
            busy_q  <= 1'b1;
            us_q    <= '0;
          end
        end
        WAIT_REL: begin
          if (line) begin
            shr_q   <= {hum_int, hum_dec, temp_int, temp_dec, csum_d};
            bit_q   <= 6'd40;
            state_q <= RESP_DELAY;
            us_q    <= '0;
          end
        end
        RESP_DELAY: begin
          if (us_q == T_DLY) begin
            state_q <= RESP_LOW;
            oe_q    <= 1'b1;
            us_q    <= '0;
          end
        end
        RESP_LOW: begin
          if (us_q == T_RESP) begin
            state_q <= RESP_HIGH;
            oe_q    <= 1'b0;
            us_q    <= '0;
          end
        end
        RESP_HIGH: begin
          if (us_q == T_RESP) begin
            state_q <= BIT_LOW;
            oe_q    <= 1'b1;
            us_q    <= '0;
          end
        end
        BIT_LOW: begin
          if (us_q == T_BLOW) begin
            state_q <= BIT_HIGH;
            oe_q    <= 1'b0;
            us_q    <= '0;
          end
        end
        BIT_HIGH: begin
          if (us_q == hi_us_d) begin
            shr_q   <= {shr_q[38:0], 1'b0};
            bit_q   <= bit_q - 6'd1;
            state_q <= (bit_q == 6'd1) ? END_LOW : BIT_LOW;
            oe_q    <= 1'b1;
            us_q    <= '0;
          end
        end
        END_LOW: begin
          if (us_q == T_END) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            us_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
          us_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Randomized bench for dht11_responder: measures data_oe run lengths
// and compares them with a frame model built from the payload bytes.
module tb_dht11_responder;

  localparam int CLK_HZ = 2_000_000;
  localparam int DIV    = CLK_HZ / 1_000_000;
  localparam int SMIN   = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       host_low;
  logic       line;
  logic       data_oe;
  logic       busy;
  logic       done;
  logic [7:0] hi, hd, ti, td;

  assign line = ~(host_low | data_oe);

  dht11_responder #(
    .CLK_HZ      (CLK_HZ),
    .START_MIN_US(SMIN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .data_in (line),
    .data_oe (data_oe),
    .hum_int (hi),
    .hum_dec (hd),
    .temp_int(ti),
    .temp_dec(td),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_runs[$];
  int exp_bytes[5];
  int runs[$];
  int delay;
  int ndone;

  task automatic chk(string tag, int got, int exp, int tol = 0);
    n_cmp++;
    if (got > exp + tol || got < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)",
               tag, got, exp, tol);
    end
  endtask

  // Reference: bytes, checksum and the us length of every line phase.
  task automatic model(input int a, input int b, input int c, input int d);
    int bt;
    exp_bytes = '{a, b, c, d, (a + b + c + d) % 256};
    exp_runs.delete();
    exp_runs.push_back(80);
    exp_runs.push_back(80);
    for (int k = 0; k < 40; k++) begin
      bt = (exp_bytes[k / 8] >> (7 - k % 8)) & 1;
      exp_runs.push_back(50);
      exp_runs.push_back(bt ? 70 : 26);
    end
    exp_runs.push_back(50);
  endtask

  task automatic start_pulse(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Run-length record of data_oe from host release until after done.
  task automatic capture(input int budget);
    int   cyc;
    int   len;
    int   post;
    logic prev;
    bit   started;
    cyc = 0; len = 0; post = 0; prev = 1'b0; started = 0;
    runs.delete();
    ndone = 0;
    delay = -1;
    while (cyc < budget && post < 40) begin
      @(negedge clk);
      cyc++;
      if (done) ndone++;
      if (ndone > 0) post++;
      if (!started) begin
        if (data_oe) begin
          started = 1; delay = cyc; prev = 1'b1; len = 1;
        end
      end else if (data_oe === prev) begin
        len++;
      end else begin
        runs.push_back(len);
        prev = data_oe;
        len = 1;
      end
    end
  endtask

  task automatic verify(string tag);
    int dec;
    int idx;
    int n;
    chk({tag, "_delay"}, delay, 30 * DIV + 3, DIV + 1);
    chk({tag, "_nruns"}, runs.size(), exp_runs.size());
    chk({tag, "_done"}, ndone, 1);
    n = (runs.size() < exp_runs.size()) ? runs.size() : exp_runs.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_run%0d", tag, i), runs[i],
          exp_runs[i] * DIV, DIV + 1);
    for (int by = 0; by < 5; by++) begin
      dec = 0;
      for (int b = 0; b < 8; b++) begin
        idx = 3 + 2 * (by * 8 + b);
        dec = dec << 1;
        if (idx < runs.size() && runs[idx] > 48 * DIV) dec = dec | 1;
      end
      chk($sformatf("%s_byte%0d", tag, by), dec, exp_bytes[by]);
    end
  endtask

  task automatic set_payload(input int a, input int b,
                             input int c, input int d);
    hi = 8'(a); hd = 8'(b); ti = 8'(c); td = 8'(d);
  endtask

  task automatic frame(string tag, input int a, input int b,
                       input int c, input int d, input bit scramble);
    set_payload(a, b, c, d);
    model(a, b, c, d);
    start_pulse(SMIN + 50);
    fork
      capture(14000);
      if (scramble) begin
        for (int k = 0; k < 3; k++) begin
          repeat ($urandom_range(2000, 10)) @(negedge clk);
          set_payload($urandom, $urandom, $urandom, $urandom);
        end
      end
    join
    verify(tag);
  endtask

  task automatic host_glitch_frame();
    int cyc;
    set_payload(17, 3, 99, 250);
    model(17, 3, 99, 250);
    start_pulse(SMIN + 50);
    fork
      capture(14000);
      begin
        cyc = 0;
        while (!data_oe && cyc < 1000) begin @(negedge clk); cyc++; end
        while (data_oe && cyc < 1000) begin @(negedge clk); cyc++; end
        repeat (10 * DIV) @(negedge clk);
        host_low = 1'b1;
        repeat (100 * DIV) @(negedge clk);
        host_low = 1'b0;
      end
    join
    verify("glitch");
  endtask

  task automatic abort(input bit use_rst);
    int   rises;
    int   cyc;
    int   nd;
    int   noe;
    logic prev;
    string tg;
    tg = use_rst ? "rst" : "en";
    rises = 0; cyc = 0; nd = 0; noe = 0; prev = 1'b0;
    set_payload($urandom, $urandom, $urandom, $urandom);
    start_pulse(SMIN + 50);
    while (rises < 18 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (data_oe && !prev) rises++;
      prev = data_oe;
    end
    chk({tg, "_reach_bit17"}, rises, 18);
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         en  = 1'b0;
    @(posedge clk);
    #1;
    chk({tg, "_oe_next"}, int'(data_oe), 0);
    chk({tg, "_busy_next"}, int'(busy), 0);
    chk({tg, "_done_next"}, int'(done), 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    repeat (600) begin
      @(negedge clk);
      if (done) nd++;
      if (data_oe) noe++;
    end
    chk({tg, "_no_done"}, nd, 0);
    chk({tg, "_no_oe"}, noe, 0);
    frame({tg, "_after"}, $urandom_range(255), $urandom_range(255),
          $urandom_range(255), $urandom_range(255), 0);
  endtask

  task automatic short_start();
    int noe;
    int nb;
    int nd;
    noe = 0; nb = 0; nd = 0;
    fork
      start_pulse(SMIN / 2);
      repeat ((SMIN / 2) * DIV + 800) begin
        @(negedge clk);
        if (data_oe) noe++;
        if (busy) nb++;
        if (done) nd++;
      end
    join
    chk("short_oe", noe, 0);
    chk("short_busy", nb, 0);
    chk("short_done", nd, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    host_low = 1'b0;
    set_payload(0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("rst_oe", int'(data_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    frame("basic", 52, 0, 24, 0, 0);
    short_start();
    frame("wrap", 8'hFF, 8'hFF, 8'hFF, 8'h02, 0);
    for (int i = 0; i < 2; i++)
      frame($sformatf("rnd%0d", i), $urandom_range(255),
            $urandom_range(255), $urandom_range(255),
            $urandom_range(255), 1);
    host_glitch_frame();
    abort(1);
    abort(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
